busarb: RTL
===========

BUSARB -- requirements
Module: busarb

Interface
REQ-001 SHALL have parameter NMASTERS, default 4: number of requesting masters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 17: bus address width.
REQ-003 SHALL have parameter DATA_W, default 8: bus data width.
REQ-004 SHALL have parameter HOLD_MAX, default 4: maximum beats per grant (1..15).
REQ-005 SHALL have port clk  in  1: single clock; all state on rising edge.
REQ-006 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-007 SHALL have port req  in  NMASTERS: per-master bus request.
REQ-008 SHALL have port inhibit  in  NMASTERS: per-master debug inhibit; masks the request.
REQ-009 SHALL have port m_we  in  NMASTERS: per-master write enable.
REQ-010 SHALL have port m_addr  in  NMASTERS*ADDR_W: packed per-master addresses, master i at slice i.
REQ-011 SHALL have port m_wdata  in  NMASTERS*DATA_W: packed per-master write data.
REQ-012 SHALL have port gnt  out  NMASTERS: registered one-hot-or-zero grant.
REQ-013 SHALL have port rvalid  out  NMASTERS: per-master read-data-valid pulse.
REQ-014 SHALL have port rdata  out  DATA_W: registered read data, shared by all masters.
REQ-015 SHALL have port bus_we  out  1: write enable to the bus controller.
REQ-016 SHALL have port bus_addr  out  ADDR_W: address to the bus controller.
REQ-017 SHALL have port bus_wdata  out  DATA_W: write data to the bus controller.
REQ-018 SHALL have port bus_rdata  in  DATA_W: bus controller read data, valid one cycle after the address.

Function
REQ-019 SHALL define effective request ereq[i] = req[i] & ~inhibit[i].
REQ-020 SHALL implement states IDLE and OWN.
REQ-021 In IDLE with any ereq, SHALL select the first set ereq searching circularly from last_owner+1, register it as the one-hot gnt, and enter OWN on the next edge.
REQ-022 Grant latency SHALL be one cycle: ereq at edge t gives gnt at t+1; IDLE with no ereq keeps gnt=0.
REQ-023 A beat SHALL be any OWN cycle in which the owner's ereq is high; during a beat, bus_we, bus_addr and bus_wdata SHALL equal the owner's slices.
REQ-024 Outside a beat, bus_we, bus_addr and bus_wdata SHALL be 0.
REQ-025 For each read beat (bus_we=0), rdata SHALL capture bus_rdata one cycle later, and rvalid[owner-of-that-beat] SHALL pulse high for exactly that cycle.
REQ-026 Write beats SHALL NOT produce rvalid.
REQ-027 A 4-bit beat counter SHALL increment on each beat and clear on entry to OWN.
REQ-028 The owner SHALL be released (gnt=0, state IDLE) on the edge after any of these: owner ereq low; the beat counter reaching HOLD_MAX.
REQ-029 On release, last_owner SHALL be updated to the released master.
REQ-030 An inhibit assertion on the owner SHALL end the beat in that same cycle (combinational mask) and release on the next edge.
REQ-031 A pending rvalid SHALL still be delivered after release.
REQ-032 With only one requester, it SHALL be re-granted after a one-cycle IDLE gap.
REQ-033 Round-robin SHALL guarantee each continuously requesting master a grant within NMASTERS arbitration rounds.

Reset
REQ-034 While reset is high, the block SHALL hold: state=IDLE, gnt=0, rvalid=0, rdata=0, bus_we=0, bus_addr=0, bus_wdata=0, beat counter=0, last_owner=NMASTERS-1.
REQ-035 Reset mid-beat SHALL abort the beat with no rvalid issued, and the first grant after reset SHALL go to master 0 if it is requesting.

Configuration
REQ-036 With BUSARB_STATS_EN defined, the block SHALL add output stat_beats (16 bits), counting all beats, saturating at 0xFFFF, and cleared by reset.
REQ-037 Without BUSARB_STATS_EN, port stat_beats and its counter SHALL be absent, with no other behavioural change.

Verification
REQ-038 Reset, then req=4'b0001 with m0 read at addr 0x00010 -> gnt=0001 at t+1; bus_addr=0x00010 and bus_we=0 at t+1; rvalid[0]=1 with rdata=bus_rdata at t+2.
REQ-039 All four masters requesting continuously, HOLD_MAX=4 -> grants in order m0, m1, m2, m3, m0; each owner gets 4 beats; one IDLE cycle between grants.
REQ-040 m2 owning with inhibit[2] raised after 2 beats -> bus_we/bus_addr go 0 in that cycle; gnt[2] drops at the next edge; the next requester is granted.
REQ-041 m1 write beat, addr 0x1FFFF, wdata 0xA5 -> bus_we=1, bus_addr=0x1FFFF, bus_wdata=0xA5 for one cycle; no rvalid.
REQ-042 Reset asserted asynchronously mid-read-beat -> all outputs 0 immediately; no rvalid after deassertion.
REQ-043 With BUSARB_STATS_EN, 70000 consecutive beats -> stat_beats saturates at 0xFFFF.

Source files
------------

// File: rtl/busarb.sv
// -----------------------------------------------------------------------------
// busarb -- round-robin bus arbiter for NMASTERS requesters sharing one bus
// controller.
//
// A master owns the bus from the cycle its gnt bit is high until it is released.
// Release happens when the owner's effective request drops, or when it has used
// HOLD_MAX beats. The owner's write enable, address and write data are steered
// onto the bus only during beats. A read beat's data is captured into rdata on
// the following edge. The matching rvalid bit pulses for that one cycle.
//
// Handshake: req[i] is a level request. The master must hold its request and
// its we/addr/wdata slices stable while it wants beats. A beat happens in every
// cycle where gnt[i] is high and (req[i] & ~inhibit[i]) is high. Dropping the
// request, or raising inhibit, ends the beat combinationally in that cycle. The
// grant is then withdrawn on the next edge.
//
// Parameters : NMASTERS (2..8), ADDR_W, DATA_W, HOLD_MAX (1..15)
// Ports
//   clk        in   clock, all state on rising edge
//   reset      in   asynchronous active-high reset
//   req        in   [NMASTERS]         per-master request
//   inhibit    in   [NMASTERS]         per-master debug inhibit (masks req)
//   m_we       in   [NMASTERS]         per-master write enable
//   m_addr     in   [NMASTERS*ADDR_W]  packed addresses, master i at slice i
//   m_wdata    in   [NMASTERS*DATA_W]  packed write data, master i at slice i
//   gnt        out  [NMASTERS]         registered one-hot-or-zero grant
//   rvalid     out  [NMASTERS]         read-data-valid pulse to the beat's owner
//   rdata      out  [DATA_W]           registered read data, shared
//   bus_we     out                     write enable to the bus controller
//   bus_addr   out  [ADDR_W]           address to the bus controller
//   bus_wdata  out  [DATA_W]           write data to the bus controller
//   bus_rdata  in   [DATA_W]           read data from the bus controller
//   stat_beats out  [16]               saturating beat count (BUSARB_STATS_EN only)
//
// Optional build macro: BUSARB_STATS_EN adds the stat_beats port and its counter.
// -----------------------------------------------------------------------------
module busarb #(
  parameter int NMASTERS = 4,
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NMASTERS-1:0]          req,
  input  logic [NMASTERS-1:0]          inhibit,
  input  logic [NMASTERS-1:0]          m_we,
  input  logic [NMASTERS*ADDR_W-1:0]   m_addr,
  input  logic [NMASTERS*DATA_W-1:0]   m_wdata,
  output logic [NMASTERS-1:0]          gnt,
  output logic [NMASTERS-1:0]          rvalid,
  output logic [DATA_W-1:0]            rdata,
  output logic                         bus_we,
  output logic [ADDR_W-1:0]            bus_addr,
  output logic [DATA_W-1:0]            bus_wdata,
  input  logic [DATA_W-1:0]            bus_rdata
`ifdef BUSARB_STATS_EN
  ,
  output logic [15:0]                  stat_beats
`endif
);

  localparam int IW = $clog2(NMASTERS);
  localparam logic [4:0] HOLD_LIMIT = 5'(HOLD_MAX);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [NMASTERS-1:0]   ereq;
  logic [NMASTERS-1:0]   gnt_nxt;
  logic [IW-1:0]         owner, owner_nxt;
  logic [IW-1:0]         last_owner, last_owner_nxt;
  logic [IW-1:0]         pick, cand;
  logic                  pick_valid;
  logic [3:0]            beat_cnt, beat_cnt_nxt;
  logic                  beat;
  logic                  owner_we;

  // Debug inhibit masks the raw request everywhere, including mid-ownership.
  assign ereq = req & ~inhibit;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int step);
    int s;
    s = (int'(base) + step) % NMASTERS;
    return IW'(s);
  endfunction

  // Round-robin pick: walk from the farthest candidate toward last_owner+1 so
  // that the closest requesting master is the last (winning) assignment.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int k = NMASTERS; k >= 1; k--) begin
      cand = wrap_idx(last_owner, k);
      if (ereq[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  // A beat is any owned cycle in which the owner still effectively requests.
  assign beat     = (state == OWN) && ereq[owner];
  assign owner_we = m_we[owner];

  // Bus steering is combinational so an inhibit kills the beat in the same cycle.
  assign bus_we    = beat ? owner_we : 1'b0;
  assign bus_addr  = beat ? m_addr[int'(owner)*ADDR_W +: ADDR_W] : '0;
  assign bus_wdata = beat ? m_wdata[int'(owner)*DATA_W +: DATA_W] : '0;

  // Next-state / grant logic.
  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt      = OWN;
          gnt_nxt        = '0;
          gnt_nxt[pick]  = 1'b1;
          owner_nxt      = pick;
          beat_cnt_nxt   = '0;
        end
      end
      OWN: begin
        if (beat) begin
          beat_cnt_nxt = beat_cnt + 4'd1;
        end
        // Release on the edge that ends the cycle where the request dropped, or
        // on the edge that completes the HOLD_MAX-th beat.
        if (!beat || (({1'b0, beat_cnt} + 5'd1) >= HOLD_LIMIT)) begin
          state_nxt      = IDLE;
          gnt_nxt        = '0;
          last_owner_nxt = owner;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      owner      <= '0;
      last_owner <= IW'(NMASTERS - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Read return: during OWN, gnt is exactly the owner's one-hot, so it doubles
  // as the rvalid pattern. The pulse is driven even if the grant is released on
  // the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid <= '0;
      rdata  <= '0;
    end else if (beat && !owner_we) begin
      rvalid <= gnt;
      rdata  <= bus_rdata;
    end else begin
      rvalid <= '0;
    end
  end

`ifdef BUSARB_STATS_EN
  logic [15:0] stat_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_cnt <= '0;
    end else if (beat && (stat_cnt != 16'hFFFF)) begin
      stat_cnt <= stat_cnt + 16'd1;
    end
  end

  assign stat_beats = stat_cnt;
`endif

endmodule
